lr_score_fsm: RTL and testbench

Left/right score controller that feeds the 3-bit code consumed by the `sev_seg2` decoder. Two push-buttons pull a signed marker between −3 (left) and +3 (right); the block synchronizes and edge-detects the buttons, runs the game state machine and emits the display code: centre, left lead, right lead or blank. It also flags the winner and optionally blinks the winning code.

---
 rtl/lr_score_fsm.sv | 176 +++++++++++++++++
 tb/tb_lr_score_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_score_fsm.sv
// lr_score_fsm: left/right score game controller producing the 3-bit sev_seg2 display code.
// Latency: 2 cycles from the button sampling edge to data/winner/playing; outputs decode registers only.
// Backpressure: none; button edges are dropped during the WIN hold. LR_SCORE_BLINK_EN blinks the WIN code.
module lr_score_fsm #(
    parameter int BLINK_DIV = 25_000_000,
    parameter int WIN_HOLD  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [2:0] data,
    output logic [1:0] winner,
    output logic       playing
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;

    localparam int              HW       = $clog2(WIN_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(WIN_HOLD);
    localparam logic signed [2:0] POS_MIN = -3'sd3;
    localparam logic signed [2:0] POS_MAX = 3'sd3;

    if (BLINK_DIV < 2 || WIN_HOLD < 1) begin : g_param_check
        $error("lr_score_fsm: BLINK_DIV must be >= 2 and WIN_HOLD >= 1");
    end

    logic              s1_l_q, s2_l_q, p_l_q, s1_r_q, s2_r_q, p_r_q;
    logic              s1_l_d, s2_l_d, p_l_d, s1_r_d, s2_r_d, p_r_d;
    logic [1:0]        state_q, state_d;
    logic signed [2:0] pos_q, pos_d, pos_nxt;
    logic [1:0]        winner_q, winner_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              edge_l, edge_r;
    logic [2:0]        code;
    logic              blank;

    assign edge_l = s2_l_q & ~p_l_q;
    assign edge_r = s2_r_q & ~p_r_q;

    always_comb begin
        s1_l_d   = btn_l;
        s2_l_d   = s1_l_q;
        p_l_d    = s2_l_q;
        s1_r_d   = btn_r;
        s2_r_d   = s1_r_q;
        p_r_d    = s2_r_q;
        state_d  = state_q;
        pos_d    = pos_q;
        pos_nxt  = pos_q;
        winner_d = winner_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_l || edge_r) begin
                    state_d = ST_PLAY;
                    pos_d   = '0;
                end
            end
            ST_PLAY: begin
                if (edge_l && !edge_r) begin
                    pos_nxt = pos_q - 3'sd1;
                end else if (edge_r && !edge_l) begin
                    pos_nxt = pos_q + 3'sd1;
                end
                pos_d  = pos_nxt;
                hold_d = '0;
                // WIN entry shares the edge that writes the final marker position
                if (pos_nxt == POS_MIN) begin
                    state_d  = ST_WIN;
                    winner_d = 2'b01;
                end else if (pos_nxt == POS_MAX) begin
                    state_d  = ST_WIN;
                    winner_d = 2'b10;
                end
            end
            ST_WIN: begin
                if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else if (edge_l || edge_r) begin
                    state_d  = ST_IDLE;
                    pos_d    = '0;
                    winner_d = 2'b00;
                    hold_d   = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pos_d    = '0;
                winner_d = 2'b00;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_l_q   <= 1'b0;
            s2_l_q   <= 1'b0;
            p_l_q    <= 1'b0;
            s1_r_q   <= 1'b0;
            s2_r_q   <= 1'b0;
            p_r_q    <= 1'b0;
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            winner_q <= 2'b00;
            hold_q   <= '0;
        end else begin
            s1_l_q   <= s1_l_d;
            s2_l_q   <= s2_l_d;
            p_l_q    <= p_l_d;
            s1_r_q   <= s1_r_d;
            s2_r_q   <= s2_r_d;
            p_r_q    <= p_r_d;
            state_q  <= state_d;
            pos_q    <= pos_d;
            winner_q <= winner_d;
            hold_q   <= hold_d;
        end
    end

`ifdef LR_SCORE_BLINK_EN
    localparam int            BW         = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // Counter and phase only run while staying in WIN, so entry and exit both see them cleared
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (state_q == ST_WIN && state_d == ST_WIN) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blank = (state_q == ST_IDLE) || (state_q == ST_WIN && phase_q);
`else
    assign blank = (state_q == ST_IDLE);
`endif

    always_comb begin
        case (pos_q)
            3'b101:  code = 3'b011;
            3'b110:  code = 3'b010;
            3'b111:  code = 3'b001;
            3'b001:  code = 3'b100;
            3'b010:  code = 3'b101;
            3'b011:  code = 3'b110;
            default: code = 3'b000;
        endcase
    end

    assign data    = blank ? 3'b111 : code;
    assign winner  = winner_q;
    assign playing = (state_q == ST_PLAY);

endmodule

// File: tb/tb_lr_score_fsm.sv
// Self-checking bench for lr_score_fsm with WIN_HOLD=8, BLINK_DIV=4; expectations flow through a scoreboard queue.
module tb_lr_score_fsm;
    localparam int BLINK_DIV = 4;
    localparam int WIN_HOLD  = 8;
`ifdef LR_SCORE_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] data;
        logic [1:0] winner;
        logic       playing;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [2:0] data;
    logic [1:0] winner;
    logic       playing;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   win_cyc0 = 0;
    obs_t exp_q[$];

    lr_score_fsm #(.BLINK_DIV(BLINK_DIV), .WIN_HOLD(WIN_HOLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .data   (data),
        .winner (winner),
        .playing(playing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic obs_t mk(input logic [2:0] d, input logic [1:0] w, input logic p);
        obs_t o;
        o.data = d; o.winner = w; o.playing = p;
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(data, winner, playing);
    endfunction

    // Expected WIN display code ofs cycles from now; cycle 0 is the first WIN cycle
    function automatic logic [2:0] win_data(input logic [2:0] code, input int ofs);
        int c;
        c = cyc - win_cyc0 + ofs;
        if (BLINK_EN && ((c / BLINK_DIV) % 2) == 1) return 3'b111;
        return code;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press sampled at the next edge k; early is seen after k+1, late after k+2
    task automatic press(input logic l, input logic r, output obs_t early, output obs_t late,
                         output int t_late);
        btn_l = l;
        btn_r = r;
        tick();
        tick();
        early = cur();
        tick();
        late   = cur();
        t_late = cyc;
        btn_l = 1'b0;
        btn_r = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        obs_t got, e;
        reset = 1'b1; btn_l = 1'b0; btn_r = 1'b0;
        exp_q.push_back(mk(3'b111, 2'b00, 1'b0));
        repeat (2) tick();
        got = cur(); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reset_idle got=%b exp=%b", got, e); end
        reset = 1'b0;
        exp_q.push_back(mk(3'b111, 2'b00, 1'b0));
        repeat (3) tick();
        got = cur(); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=%b", got, e); end
    endtask

    task automatic test_start_latency();
        obs_t g0, g1, e;
        int t;
        obs_t ee[2], el[2];
        ee[0] = mk(3'b111, 2'b00, 1'b0); el[0] = mk(3'b000, 2'b00, 1'b1);
        ee[1] = mk(3'b000, 2'b00, 1'b1); el[1] = mk(3'b100, 2'b00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ee[i]);
            exp_q.push_back(el[i]);
            press(1'b0, 1'b1, g0, g1, t);
            e = exp_q.pop_front(); n_tests++;
            if (g0 !== e) begin n_fail++; $display("FAIL start_early[%0d] got=%b exp=%b", i, g0, e); end
            e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL start_late[%0d] got=%b exp=%b", i, g1, e); end
        end
    endtask

    task automatic test_simul_held();
        obs_t g0, g1, e;
        int t;
        // both buttons at pos +1: no move
        exp_q.push_back(mk(3'b100, 2'b00, 1'b1));
        exp_q.push_back(mk(3'b100, 2'b00, 1'b1));
        press(1'b1, 1'b1, g0, g1, t);
        e = exp_q.pop_front(); n_tests++;
        if (g0 !== e) begin n_fail++; $display("FAIL simul_early got=%b exp=%b", g0, e); end
        e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL simul_late got=%b exp=%b", g1, e); end
        // held left button: exactly one move back to centre
        exp_q.push_back(mk(3'b000, 2'b00, 1'b1));
        btn_l = 1'b1;
        repeat (20) tick();
        btn_l = 1'b0;
        repeat (3) tick();
        g1 = cur(); e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL held_one_move got=%b exp=%b", g1, e); end
        // walk to +2 then reset mid-PLAY
        exp_q.push_back(mk(3'b100, 2'b00, 1'b1));
        exp_q.push_back(mk(3'b101, 2'b00, 1'b1));
        for (int i = 0; i < 2; i++) begin
            press(1'b0, 1'b1, g0, g1, t);
            e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL walk_right[%0d] got=%b exp=%b", i, g1, e); end
        end
        exp_q.push_back(mk(3'b111, 2'b00, 1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        g1 = cur(); e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL reset_mid_play got=%b exp=%b", g1, e); end
    endtask

    task automatic test_left_win();
        obs_t g0, g1, e;
        int t;
        obs_t ee[4], el[4];
        ee[0] = mk(3'b111, 2'b00, 1'b0); el[0] = mk(3'b000, 2'b00, 1'b1);
        ee[1] = mk(3'b000, 2'b00, 1'b1); el[1] = mk(3'b001, 2'b00, 1'b1);
        ee[2] = mk(3'b001, 2'b00, 1'b1); el[2] = mk(3'b010, 2'b00, 1'b1);
        ee[3] = mk(3'b010, 2'b00, 1'b1); el[3] = mk(3'b011, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ee[i]);
            exp_q.push_back(el[i]);
            press(1'b1, 1'b0, g0, g1, t);
            e = exp_q.pop_front(); n_tests++;
            if (g0 !== e) begin n_fail++; $display("FAIL lwin_early[%0d] got=%b exp=%b", i, g0, e); end
            e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL lwin_late[%0d] got=%b exp=%b", i, g1, e); end
        end
        win_cyc0 = t;
        while (cyc - win_cyc0 < 5) begin
            tick();
            exp_q.push_back(mk(win_data(3'b011, 0), 2'b01, 1'b0));
            g1 = cur(); e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL lwin_hold c=%0d got=%b exp=%b", cyc - win_cyc0, g1, e); end
        end
        // pressed at WIN cycle 5: its edge meets hold_cnt 7 and must be ignored
        exp_q.push_back(mk(win_data(3'b011, 2), 2'b01, 1'b0));
        exp_q.push_back(mk(win_data(3'b011, 3), 2'b01, 1'b0));
        press(1'b0, 1'b1, g0, g1, t);
        e = exp_q.pop_front(); n_tests++;
        if (g0 !== e) begin n_fail++; $display("FAIL lwin_ignore_early got=%b exp=%b", g0, e); end
        e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL lwin_ignore_late got=%b exp=%b", g1, e); end
        while (cyc - win_cyc0 < 20) begin
            tick();
            exp_q.push_back(mk(win_data(3'b011, 0), 2'b01, 1'b0));
            g1 = cur(); e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL lwin_blink c=%0d got=%b exp=%b", cyc - win_cyc0, g1, e); end
        end
        exp_q.push_back(mk(win_data(3'b011, 2), 2'b01, 1'b0));
        exp_q.push_back(mk(3'b111, 2'b00, 1'b0));
        press(1'b0, 1'b1, g0, g1, t);
        e = exp_q.pop_front(); n_tests++;
        if (g0 !== e) begin n_fail++; $display("FAIL lwin_exit_early got=%b exp=%b", g0, e); end
        e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL lwin_exit_late got=%b exp=%b", g1, e); end
    endtask

    task automatic test_right_win_blink();
        obs_t g0, g1, e;
        int t;
        obs_t el[4];
        el[0] = mk(3'b000, 2'b00, 1'b1);
        el[1] = mk(3'b100, 2'b00, 1'b1);
        el[2] = mk(3'b101, 2'b00, 1'b1);
        el[3] = mk(3'b110, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(el[i]);
            press(1'b0, 1'b1, g0, g1, t);
            e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL rwin_late[%0d] got=%b exp=%b", i, g1, e); end
        end
        win_cyc0 = t;
        while (cyc - win_cyc0 < 6) begin
            tick();
            exp_q.push_back(mk(win_data(3'b110, 0), 2'b10, 1'b0));
            g1 = cur(); e = exp_q.pop_front(); n_tests++;
            if (g1 !== e) begin n_fail++; $display("FAIL rwin_blink c=%0d got=%b exp=%b", cyc - win_cyc0, g1, e); end
        end
        // pressed at WIN cycle 6: edge meets hold_cnt == WIN_HOLD, first accepted cycle
        exp_q.push_back(mk(win_data(3'b110, 2), 2'b10, 1'b0));
        exp_q.push_back(mk(3'b111, 2'b00, 1'b0));
        press(1'b1, 1'b0, g0, g1, t);
        e = exp_q.pop_front(); n_tests++;
        if (g0 !== e) begin n_fail++; $display("FAIL rwin_exit_early got=%b exp=%b", g0, e); end
        e = exp_q.pop_front(); n_tests++;
        if (g1 !== e) begin n_fail++; $display("FAIL rwin_exit_late got=%b exp=%b", g1, e); end
    endtask

    initial begin
        tick();
        test_reset();
        test_start_latency();
        test_simul_held();
        test_left_win();
        test_right_win_blink();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
